div8u4_seq: RTL and testbench

- Sequential unsigned restoring divider: the inverse operation of the team's 4-bit unsigned multipliers.
- Takes an 8-bit dividend (e.g. a 4x4 product) and a 4-bit divisor, and returns the 8-bit quotient and 4-bit remainder.
- Computes one quotient bit per cycle.
- Re-multiplies the result through an internal 4x8 combinational multiplier to self-check, so a fault in the datapath is flagged at the outputs rather than passed on silently.

---
 rtl/div_pkg.sv | 19 +
 rtl/div8u4_seq_mulchk_u.sv | 20 ++
 rtl/div8u4_seq.sv | 119 +++++++++++
 tb/tb_div8u4_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential unsigned divider.
//   state_t      : controller states
//   DW_DEF/VW_DEF: default dividend/quotient and divisor/remainder widths
//   DBZ_QUOTIENT : quotient reported on divide-by-zero (all ones, sliced to DW)
package div_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned VW_DEF = 4;

  localparam logic [63:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/div8u4_seq_mulchk_u.sv
// Combinational unsigned multiply-accumulate used to verify a division result.
//   q   : quotient (DW bits)
//   d   : divisor (VW bits)
//   r   : remainder (VW bits)
//   sum : q*d + r at DW+VW bits (cannot overflow for r < d)
module mulchk_u #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input  logic [DW-1:0]    q,
  input  logic [VW-1:0]    d,
  input  logic [VW-1:0]    r,
  output logic [DW+VW-1:0] sum
);

  always_comb begin
    sum = (DW+VW)'(q) * (DW+VW)'(d) + (DW+VW)'(r);
  end

endmodule

// File: rtl/div8u4_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// with a multiply-back self-check of every result.
//   clk, rst             : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only when idle)
//   dividend, divisor    : DW-bit and VW-bit unsigned operands
//   out_valid / out_ready: result handshake
//   quotient, remainder  : DW-bit and VW-bit unsigned result
//   dbz                  : divisor was zero (qualified by out_valid)
//   check_err            : q*d + r did not reproduce the dividend, or r >= d
module div8u4_seq
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz,
  output logic          check_err
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  state_t          state, state_n;
  logic [DW-1:0]   q;       // quotient shift register, starts holding the dividend
  logic [VW:0]     rem;     // partial remainder, one guard bit wide
  logic [VW-1:0]   d;       // latched divisor
  logic [DW-1:0]   dvd;     // latched dividend for the self-check
  logic [CW-1:0]   cnt;
  logic            err_r;
  logic            dbz_r;

  logic [VW:0]     t;
  logic            ge;
  logic [VW:0]     rem_n;
  logic [DW-1:0]   q_n;
  logic [DW+VW-1:0] chk_sum;

  mulchk_u #(.DW(DW), .VW(VW)) u_mulchk (
    .q   (q),
    .d   (d),
    .r   (rem[VW-1:0]),
    .sum (chk_sum)
  );

  always_comb begin
    state_n = state;
    t       = {rem[VW-1:0], q[DW-1]};
    ge      = (t >= {1'b0, d});
    rem_n   = ge ? (t - {1'b0, d}) : t;
    q_n     = {q[DW-2:0], ge};
    case (state)
      IDLE:  if (in_valid) state_n = (divisor == '0) ? HOLD : CALC;
      CALC:  if (cnt == CW'(DW-1)) state_n = CHECK;
      CHECK: state_n = HOLD;
      HOLD:  if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      rem   <= '0;
      d     <= '0;
      dvd   <= '0;
      cnt   <= '0;
      dbz_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd   <= dividend;
            d     <= divisor;
            cnt   <= '0;
            err_r <= 1'b0;
            if (divisor == '0) begin
              q     <= DBZ_QUOTIENT[DW-1:0];
              rem   <= {1'b0, dividend[VW-1:0]};
              dbz_r <= 1'b1;
            end else begin
              q     <= dividend;
              rem   <= '0;
              dbz_r <= 1'b0;
            end
          end
        end
        CALC: begin
          q   <= q_n;
          rem <= rem_n;
          cnt <= cnt + 1'b1;
        end
        CHECK: begin
          err_r <= (chk_sum != {{VW{1'b0}}, dvd}) || (rem >= {1'b0, d});
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign quotient  = q;
  assign remainder = rem[VW-1:0];
  assign dbz       = dbz_r;
  assign check_err = err_r;

endmodule

// File: tb/tb_div8u4_seq.sv
module tb_div8u4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dbz;
  logic       check_err;

  int n_cmp = 0;
  int n_mis = 0;

  div8u4_seq #(.DW(8), .VW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .check_err (check_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {check_err, dbz, remainder, quotient}
  function automatic logic [31:0] pack_res();
    return {18'd0, check_err, dbz, remainder, quotient};
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called #1 after a posedge. Returns after the accept edge (+#1).
  task automatic start(input logic [7:0] dv, input logic [3:0] ds);
    for (int i = 0; i < 64; i++) begin
      if (in_ready) break;
      @(posedge clk); #1;
    end
    if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; dividend = dv; divisor = ds;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 8'($urandom); divisor = 4'($urandom);
  endtask

  // Counts cycles after the accept edge until out_valid is seen (sampled on negedge).
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) lat = 999;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] held;
    logic seen;

    do_reset();
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_res", pack_res(), 32'd0);

    // 143 / 11 = 13 r 0, latency 10
    start(8'd143, 4'd11);
    wait_valid(lat);
    check("lat_143_11", lat, 32'd10);
    check("res_143_11", pack_res(), {18'd0, 1'b0, 1'b0, 4'd0, 8'd13});
    consume();
    check("cons_valid", {31'd0, out_valid}, 32'd0);

    // 255 / 1, then 200 / 15 presented while the first result is consumed
    start(8'd255, 4'd1);
    wait_valid(lat);
    check("lat_255_1", lat, 32'd10);
    check("res_255_1", pack_res(), {18'd0, 1'b0, 1'b0, 4'd0, 8'd255});
    in_valid = 1'b1; dividend = 8'd200; divisor = 4'd15; out_ready = 1'b1;
    @(posedge clk); #1;            // consume edge: not accepted here
    out_ready = 1'b0;
    check("simul_idle", {30'd0, in_ready, out_valid}, 32'b10);
    @(posedge clk); #1;            // accept edge in IDLE
    in_valid = 1'b0; dividend = 8'd3; divisor = 4'd7;
    check("simul_acc", {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    check("lat_200_15", lat, 32'd10);
    check("res_200_15", pack_res(), {18'd0, 1'b0, 1'b0, 4'd5, 8'd13});
    consume();

    // divide by zero
    start(8'd77, 4'd0);
    wait_valid(lat);
    check("lat_dbz", lat, 32'd1);
    check("res_dbz", pack_res(), {18'd0, 1'b0, 1'b1, 4'd13, 8'd255});
    consume();

    // back-pressure: hold 20 cycles with out_ready low
    start(8'd100, 4'd7);
    wait_valid(lat);
    check("res_100_7", pack_res(), {18'd0, 1'b0, 1'b0, 4'd2, 8'd14});
    held = pack_res();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_res", pack_res(), held);
      check("hold_hs", {30'd0, out_valid, in_ready}, 32'b10);
    end
    consume();
    check("rel_hs", {30'd0, out_valid, in_ready}, 32'b01);

    // reset during CALC cycle 4
    start(8'd250, 4'd3);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_hs", {30'd0, out_valid, in_ready}, 32'b01);
    check("mid_rst_res", pack_res(), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_noout", {31'd0, seen}, 32'd0);
    @(posedge clk); #1;
    start(8'd6, 4'd3);
    wait_valid(lat);
    check("res_6_3", pack_res(), {18'd0, 1'b0, 1'b0, 4'd0, 8'd2});
    consume();

    // exhaustive sweep, random back-pressure
    for (int dv = 0; dv < 256; dv++) begin
      for (int ds = 1; ds < 16; ds++) begin
        logic [7:0] eq;
        logic [3:0] er;
        eq = 8'(dv / ds);
        er = 4'(dv % ds);
        start(8'(dv), 4'(ds));
        wait_valid(lat);
        check("sweep_lat", lat, 32'd10);
        check("sweep_res", pack_res(), {18'd0, 1'b0, 1'b0, er, eq});
        for (int i = 0; i < 64; i++) begin
          out_ready = (i == 63) ? 1'b1 : 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          if (out_ready) break;
        end
        out_ready = 1'b0;
      end
    end

    // stuck quotient register must be flagged by the self-check
    start(8'd143, 4'd11);
    force dut.q = 8'd12;
    wait_valid(lat);
    check("stuck_err", {31'd0, check_err}, 32'd1);
    release dut.q;
    consume();
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
